alu_result_buf: RTL

- Downstream stage of the combinational ALU: captures ALU result plus overflow/zero/sign flags into a small FIFO with valid/ready handshakes on both sides.
- Decouples the ALU from a stalling consumer (writeback/register file).
- Maintains a sticky overflow status bit for software polling.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_result_buf_mem.sv | 27 ++
 rtl/alu_result_buf.sv | 114 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU result buffer.
// Defines the ALU flag struct and the width of one buffered entry.
// Optional macro ALU_RESULT_BUF_PARITY_EN adds one parity bit per entry.
package alu_pkg;

  // Flags exactly as produced by the ALU; stored and returned unmodified.
  typedef struct packed {
    logic ovf;
    logic zero;
    logic sign;
  } alu_flags_t;

  localparam int FLAGS_W = $bits(alu_flags_t);

`ifdef ALU_RESULT_BUF_PARITY_EN
  localparam int PARITY_W = 1;
`else
  localparam int PARITY_W = 0;
`endif

  // Entry layout, MSB to LSB: {result, flags[, parity]}.
  function automatic int entry_width(input int bitwidth);
    return bitwidth + FLAGS_W + PARITY_W;
  endfunction

endpackage

// File: rtl/alu_result_buf_mem.sv
// Storage array for the ALU result buffer: one write port, one async read port.
// Ports: clk; we/waddr/wdata write on the rising edge; raddr -> rdata combinational.
// Contents are deliberately not reset; the control block tracks validity.
module alu_result_buf_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_result_buf.sv
// Small FIFO behind the ALU: buffers result + ovf/zero/sign with valid/ready on both sides.
// Latency one cycle (no empty bypass); in_ready depends only on registered count, so a full
// buffer refuses a push even when a pop happens the same cycle. Sticky overflow bit for polling.
// Ports: clk, rst (sync, active-high); in_* producer side; out_* consumer side; count; sticky_ovf/sticky_clr.
// Optional macro ALU_RESULT_BUF_PARITY_EN adds out_parity (even parity of the stored result).
module alu_result_buf
  import alu_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BITWIDTH-1:0]        in_result,
  input  logic                       in_ovf,
  input  logic                       in_zero,
  input  logic                       in_sign,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BITWIDTH-1:0]        out_result,
  output logic                       out_ovf,
  output logic                       out_zero,
  output logic                       out_sign,
`ifdef ALU_RESULT_BUF_PARITY_EN
  output logic                       out_parity,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       sticky_ovf,
  input  logic                       sticky_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = entry_width(BITWIDTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          sticky_q, sticky_d;

  logic          push, pop;
  logic [EW-1:0] wdata, rdata;
  alu_flags_t    wflags, rflags;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign wflags = '{ovf: in_ovf, zero: in_zero, sign: in_sign};
`ifdef ALU_RESULT_BUF_PARITY_EN
  assign wdata = {in_result, wflags, ^in_result};
`else
  assign wdata = {in_result, wflags};
`endif

  // A handshake coinciding with reset is discarded, so suppress the write too.
  alu_result_buf_mem #(
    .DEPTH(DEPTH),
    .WIDTH(EW),
    .AW   (AW)
  ) u_mem (
    .clk  (clk),
    .we   (push & ~rst),
    .waddr(wr_ptr_q),
    .wdata(wdata),
    .raddr(rd_ptr_q),
    .rdata(rdata)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;  // wraps naturally, DEPTH is a power of two
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    // Set has priority over a simultaneous clear so no overflow is ever lost.
    if (push && in_ovf)  sticky_d = 1'b1;
    else if (sticky_clr) sticky_d = 1'b0;
    else                 sticky_d = sticky_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

  // Storage is unreset, so outputs are gated to zero whenever the buffer is empty.
  assign rflags     = alu_flags_t'(rdata[EW-1-BITWIDTH -: FLAGS_W]);
  assign out_result = out_valid ? rdata[EW-1 -: BITWIDTH] : '0;
  assign out_ovf    = out_valid & rflags.ovf;
  assign out_zero   = out_valid & rflags.zero;
  assign out_sign   = out_valid & rflags.sign;
`ifdef ALU_RESULT_BUF_PARITY_EN
  assign out_parity = out_valid & rdata[0];
`endif

  assign count      = count_q;
  assign sticky_ovf = sticky_q;

endmodule
